// File: rtl/pwm_table_player.sv
// Plays a stored sample table as PWM: one table entry per PWM period, duty = sample value.
// Owns the table read address while busy; never writes the table.
module pwm_table_player #(
  parameter int data_width = 8,
  parameter int addr_width = 7,
  parameter int table_len  = 100
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Enable,
  input  logic [data_width-1:0] tableData,
  output logic [addr_width-1:0] address,
  output logic                  PWM,
  output logic                  sampleStrobe,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  // Period is 2^w - 1 cycles, so the counter tops out at 2^w - 2; duty = all-ones stays high throughout.
  localparam logic [data_width-1:0] CNT_LAST  = {data_width{1'b1}} - data_width'(1);
  localparam logic [addr_width-1:0] ADDR_LAST = addr_width'(table_len - 1);

  state_t                state_q;
  logic                  prime_q;
  logic [addr_width-1:0] addr_q;
  logic [data_width-1:0] duty_q;
  logic [data_width-1:0] cnt_q;
  logic                  strobe_q;
  logic                  busy_q;

  function automatic logic [addr_width-1:0] next_addr(input logic [addr_width-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + addr_width'(1);
  endfunction

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      prime_q  <= 1'b0;
      addr_q   <= '0;
      duty_q   <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          addr_q <= '0;
          if (Enable) begin
            state_q <= PRIME;
            prime_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        PRIME: begin
          // First cycle only covers the synchronous read latency of index 0.
          if (!prime_q) begin
            prime_q <= 1'b1;
          end else begin
            duty_q   <= tableData;
            cnt_q    <= '0;
            addr_q   <= next_addr(addr_q);
            strobe_q <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            if (Enable) begin
              duty_q   <= tableData;
              cnt_q    <= '0;
              addr_q   <= next_addr(addr_q);
              strobe_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              addr_q  <= '0;
              duty_q  <= '0;
              cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + data_width'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address      = addr_q;
  assign PWM          = (state_q == RUN) && (cnt_q < duty_q);
  assign sampleStrobe = strobe_q;
  assign busy         = busy_q;

endmodule

// File: doc/pwm_table_player.md
# pwm_table_player

Downstream consumer of the signal table RAM: sweeps the table address, reads one stored sample per PWM period and turns it into a single-bit PWM output whose duty cycle equals the sample value. It owns the table's read address while running and never writes the table. Sits between the signal table and the output pin / power stage.

## Interface
- `data_width`, default 8: sample width; also PWM counter width.
- `addr_width`, default 7: table address width.
- `table_len`, default 100: number of samples played, 1..2^addr_width; indices 0..table_len-1.
- `Clk`  in  1: single clock, rising edge.
- `Rst`  in  1: reset, asynchronous, active-high.
- `Enable`  in  1: start/continue playback, level sensitive.
- `tableData`  in  data_width: sample from signal table `dataOut`; synchronous read, valid one cycle after the address is presented.
- `address`  out  addr_width: read address driven to signal table.
- `PWM`  out  1: modulated output.
- `sampleStrobe`  out  1: one-cycle pulse each time a new sample is loaded into the duty register.
- `busy`  out  1: high in PRIME and RUN.

## Operation
- States: IDLE, PRIME, RUN. Registers: `state`, `address`, `duty` (data_width), `cnt` (data_width).
- Reset (async, any state): state=IDLE, address=0, duty=0, cnt=0; outputs PWM=0, sampleStrobe=0, busy=0.
- IDLE: address held 0, PWM=0. Enable=1 sampled on an edge -> PRIME.
- PRIME (exactly 2 cycles, Enable ignored): cycle 1 waits for table read of index 0; cycle 2 edge captures duty<=tableData, cnt<=0, address<=next(0), sampleStrobe=1 for the following cycle, -> RUN.
- next(i) = i+1, or 0 when i = table_len-1 (table_len=1: address stays 0).
- RUN: cnt increments 0..P-1, P = 2^data_width - 1 (255 for default). PWM = 1 when cnt < duty (unsigned), else 0; PWM decoded from registered state/cnt/duty only, no input path.
- Duty range: duty=0 -> PWM never high; duty=P (255) -> PWM high whole period; duty=d -> exactly d high cycles then P-d low cycles per period.
- Period end (cnt = P-1 edge): if Enable=1: duty<=tableData, cnt<=0, address<=next(address), sampleStrobe pulse; stay RUN. If Enable=0: -> IDLE, address<=0, duty<=0, no strobe, no capture.
- Enable deasserted mid-period: current period completes unchanged; exit only at period end. Reasserted before period end: no effect (playback continues).
- Address is updated at the start of each period and held for P cycles, so tableData is stable long before capture; upstream writes to the current address during a period are picked up at that period's end.
- sampleStrobe and busy registered; busy=0 in IDLE.

## Timing
- Enable sampled at edge E0 -> PRIME in cycle after E0; busy rises after E0.
- duty for sample 0 loaded at E0+2; first RUN cycle (cnt=0) follows; PWM for sample 0 begins 2 cycles after Enable edge plus one.
- Sample k (k>=1) loaded at the edge ending period k-1; each sample occupies exactly P cycles of PWM; no gap cycles between periods.
- sampleStrobe high for exactly one cycle per loaded sample, coincident with cnt=0.
- Address sequence across periods: 1,2,...,table_len-1,0,1,...; wrap with no skipped or repeated index.
- After Enable=0 at period end: IDLE next cycle, PWM=0, busy=0, address=0.
- Rst mid-RUN: outputs to reset values immediately (asynchronously); restart requires Enable after Rst release and replays from index 0 with PRIME.

## Test plan
- Table preloaded 0..9 in indices 0..9, table_len=10, Enable held 1 -> sample k gives exactly k high cycles then 255-k low per 255-cycle period; address sequence 1..9,0,1; one sampleStrobe per period.
- Table entries 0 and 255 -> PWM constant 0 for full period, constant 1 for full period; no glitch at period boundary.
- table_len=1, entry 128 -> address stays 0; PWM 128 high / 127 low repeating; strobe every 255 cycles.
- Enable dropped at cnt=50 of a period with duty=20 -> period completes (20 high, 235 low), IDLE at end, busy=0, address=0, no extra strobe.
- Rst pulsed at cnt=100 in RUN -> PWM, busy, sampleStrobe, address go 0 asynchronously; re-Enable -> PRIME, sample 0 replayed.
- Table index 3 rewritten (value 7 -> 200) while index 3 is addressed -> captured duty at period end = 200.
